rotate_sram_sched: RTL and testbench

- Schedules the single external SRAM port shared by the rotator write stream and the raster read-out stream.
- Writes come from the rotator's round-robin FIFO drain (address + 16b Y/UV word). Reads fetch the previous completed frame in linear address order for the output stream.
- Ping-pong banking: the bank being written toggles on each frame sync; the read engine always reads the other bank.

---
 rtl/rotate_sram_sched.sv | 201 ++++++++++++++++++++
 tb/tb_rotate_sram_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_sram_sched.sv
// rtl/rotate_sram_sched.sv - single-port SRAM scheduler for rotator writes and raster read-out
module rotate_sram_sched #(
  parameter int ADDR_WIDTH   = 22,
  parameter int RD_LATENCY   = 2,
  parameter int RD_CREDITS   = 4,
  parameter int WR_BURST_MAX = 8
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  enable,
  input  logic                  frame_sync,
  input  logic [ADDR_WIDTH-1:0] frame_words,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [15:0]           wr_data,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH:0]   sram_addr,
  output logic [15:0]           sram_wdata,
  input  logic [15:0]           sram_rdata,
  output logic                  rdo_valid,
  input  logic                  rdo_ready,
  output logic [15:0]           rdo_data,
  output logic                  rdo_last,
  output logic                  rd_overrun,
  output logic                  busy
);

  localparam int PW = $clog2(RD_CREDITS);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(WR_BURST_MAX + 1);

  typedef enum logic {RD_IDLE, RD_ACTIVE} rd_state_t;

  rd_state_t             rd_state, rd_state_nxt;
  logic                  wbank, frame_valid;
  logic                  rbank, rbank_nxt;
  logic [ADDR_WIDTH-1:0] raddr, raddr_nxt;
  logic [ADDR_WIDTH-1:0] rlen, rlen_nxt;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         wburst;
  logic                  sync_en, rd_start, rd_is_last;
  logic                  rd_elig, wr_elig, grant_wr, grant_rd;
  logic                  rd_last_q;
  logic [RD_LATENCY-1:0] vld_sr, last_sr;
  logic [15:0]           fifo_data [RD_CREDITS];
  logic [RD_CREDITS-1:0] fifo_last;
  logic [PW:0]           wptr, rptr;
  logic                  push, pop;

  assign sync_en    = frame_sync && enable;
  assign rd_start   = sync_en && frame_valid;
  assign rd_is_last = (raddr == rlen - ADDR_WIDTH'(1));

  // Arbitration: write has priority until it has won WR_BURST_MAX times in a row against a waiting read
  always_comb begin
    rd_elig  = enable && (rd_state == RD_ACTIVE) && (cnt < CW'(RD_CREDITS));
    wr_elig  = enable && wr_valid;
    grant_wr = wr_elig && (!rd_elig || (wburst != BW'(WR_BURST_MAX)));
    grant_rd = rd_elig && !grant_wr;
  end

  // Reset gates the combinational handshake so every output reads 0 while resetb is low
  assign wr_ready = grant_wr && resetb;

  // Read FSM next state: a start always wins over an in-progress grant, giving restart-on-overrun
  always_comb begin
    rd_state_nxt = rd_state;
    rbank_nxt    = rbank;
    raddr_nxt    = raddr;
    rlen_nxt     = rlen;
    if (rd_start) begin
      rbank_nxt    = wbank;
      raddr_nxt    = '0;
      rlen_nxt     = frame_words;
      rd_state_nxt = (frame_words != '0) ? RD_ACTIVE : RD_IDLE;
    end else begin
      case (rd_state)
        RD_ACTIVE: begin
          if (grant_rd) begin
            raddr_nxt = raddr + ADDR_WIDTH'(1);
            if (rd_is_last) rd_state_nxt = RD_IDLE;
          end
        end
        default: rd_state_nxt = RD_IDLE;
      endcase
    end
  end

  // Read FSM state and read-engine registers
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rd_state <= RD_IDLE;
      rbank    <= 1'b0;
      raddr    <= '0;
      rlen     <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      rbank    <= rbank_nxt;
      raddr    <= raddr_nxt;
      rlen     <= rlen_nxt;
    end
  end

  // Bank ping-pong, frame tracking and sticky overrun flag
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wbank       <= 1'b0;
      frame_valid <= 1'b0;
      rd_overrun  <= 1'b0;
    end else if (sync_en) begin
      wbank       <= ~wbank;
      frame_valid <= 1'b1;
      if (frame_valid && (rd_state == RD_ACTIVE)) rd_overrun <= 1'b1;
    end
  end

  // Consecutive-write counter; held while disabled
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wburst <= '0;
    end else if (enable) begin
      if (grant_rd || !rd_elig) wburst <= '0;
      else if (grant_wr)        wburst <= wburst + BW'(1);
    end
  end

  // Credit counter: reads in flight plus words parked in the output FIFO
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt <= '0;
    end else begin
      case ({grant_rd, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Registered SRAM command port
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      sram_en    <= grant_wr || grant_rd;
      sram_we    <= grant_wr;
      sram_addr  <= grant_wr ? {wbank, wr_addr} : (grant_rd ? {rbank, raddr} : '0);
      sram_wdata <= grant_wr ? wr_data : '0;
      rd_last_q  <= grant_rd && rd_is_last;
    end
  end

  // Return-path valid/last shift register aligned to the SRAM read latency
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
      vld_sr[0]  <= sram_en && !sram_we;
      last_sr[0] <= rd_last_q;
    end
  end

  assign push = vld_sr[RD_LATENCY-1];
  assign pop  = rdo_valid && rdo_ready;

  // Output FIFO pointers; credits guarantee a push never finds it full
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (PW+1)'(1);
      if (pop)  rptr <= rptr + (PW+1)'(1);
    end
  end

  // Output FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wptr[PW-1:0]] <= sram_rdata;
      fifo_last[wptr[PW-1:0]] <= last_sr[RD_LATENCY-1];
    end
  end

  assign rdo_valid = (wptr != rptr);
  assign rdo_data  = rdo_valid ? fifo_data[rptr[PW-1:0]] : 16'h0000;
  assign rdo_last  = rdo_valid && fifo_last[rptr[PW-1:0]];
  assign busy      = (rd_state == RD_ACTIVE) || (sram_en && !sram_we) || (|vld_sr);

endmodule

// File: tb/tb_rotate_sram_sched.sv
// tb/tb_rotate_sram_sched.sv - scoreboard bench for rotate_sram_sched
module tb_rotate_sram_sched;

  logic        clk = 1'b0;
  logic        resetb, enable, frame_sync, wr_valid, wr_ready;
  logic [21:0] frame_words, wr_addr;
  logic [15:0] wr_data, sram_wdata, sram_rdata, rdo_data;
  logic        sram_en, sram_we, rdo_valid, rdo_ready, rdo_last, rd_overrun, busy;
  logic [22:0] sram_addr;

  rotate_sram_sched dut (
    .clk(clk), .resetb(resetb), .enable(enable), .frame_sync(frame_sync),
    .frame_words(frame_words), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .sram_en(sram_en), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .rdo_valid(rdo_valid), .rdo_ready(rdo_ready), .rdo_data(rdo_data),
    .rdo_last(rdo_last), .rd_overrun(rd_overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rcount = 0;
  int wcount = 0;
  logic wbank_m = 1'b0;
  logic log_en = 1'b0;
  logic op_log [$];
  logic [16:0] exp_q [$];
  logic [15:0] ref_mem [int];
  logic [15:0] sram_mem [int];
  logic [15:0] rd_p1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic b, input int a);
    int key = (int'(b) << 22) | a;
    return ref_mem.exists(key) ? ref_mem[key] : 16'hDEAD;
  endfunction

  // SRAM model with two-cycle read latency
  always @(posedge clk) begin
    if (sram_en && sram_we) sram_mem[int'(sram_addr)] = sram_wdata;
    if (sram_en && !sram_we)
      rd_p1 <= sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : 16'hDEAD;
    else
      rd_p1 <= 16'h0000;
    sram_rdata <= rd_p1;
  end

  // Op counters and scoreboard consumer
  always @(negedge clk) begin
    logic [16:0] e;
    if (sram_en) begin
      if (sram_we) wcount++; else rcount++;
      if (log_en) op_log.push_back(sram_we);
    end
    if (resetb && rdo_valid && rdo_ready) begin
      if (exp_q.size() == 0) check("unexpected_rdo", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("rdo_data", rdo_data, e[15:0]);
        check("rdo_last", rdo_last, e[16]);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_sync(input int fw);
    frame_sync = 1'b1; frame_words = 22'(fw);
    tick();
    frame_sync = 1'b0;
    wbank_m = ~wbank_m;
  endtask

  task automatic do_write(input int a, input logic [15:0] d);
    int n = 0;
    wr_valid = 1'b1; wr_addr = 22'(a); wr_data = d;
    @(negedge clk);
    while (!wr_ready && n < 50) begin @(negedge clk); n++; end
    check("wr_timeout", n < 50, 1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    check("wr_en", {sram_en, sram_we}, 2'b11);
    check("wr_addr", sram_addr, {wbank_m, 22'(a)});
    check("wr_data", sram_wdata, d);
    ref_mem[(int'(wbank_m) << 22) | a] = d;
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy || rdo_valid) && n < max) begin tick(); n++; end
    check("drain_timeout", n < max, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sram"}, {sram_en, sram_we, sram_addr, sram_wdata}, 0);
    check({tag, "_rdo"}, {rdo_valid, rdo_data, rdo_last}, 0);
    check({tag, "_flags"}, {rd_overrun, busy, wr_ready}, 0);
  endtask

  initial begin
    int rc0, wc0, acc, k;
    resetb = 1'b0; enable = 1'b1; frame_sync = 1'b0; frame_words = '0;
    wr_valid = 1'b1; wr_addr = '0; wr_data = '0; rdo_ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    wr_valid = 1'b0;
    resetb = 1'b1;
    tick();

    // Basic frame: first sync starts nothing, second reads the written bank
    pulse_sync(4);
    repeat (5) tick();
    check("first_sync_busy", busy, 0);
    check("first_sync_reads", rcount, 0);
    for (int i = 0; i < 4; i++) do_write(i, 16'h1000 + 16'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, exp_word(wbank_m, i)});
    rc0 = rcount;
    pulse_sync(4);
    wait_drain(200);
    check("basic_reads", rcount - rc0, 4);

    // Arbitration: continuous writes against an active read
    for (int i = 0; i < 40; i++) exp_q.push_back({i == 39, exp_word(wbank_m, i)});
    pulse_sync(40);
    log_en = 1'b1; op_log.delete();
    wc0 = wcount; acc = 0; k = 0;
    for (int c = 0; c < 90; c++) begin
      wr_valid = 1'b1; wr_addr = 22'(k); wr_data = 16'h2000 + 16'(k);
      @(negedge clk);
      if (wr_ready) begin
        ref_mem[(int'(wbank_m) << 22) | k] = wr_data;
        k++; acc++;
      end
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    repeat (2) tick();
    log_en = 1'b0;
    check("arb_log_len", op_log.size() >= 81, 1);
    for (int i = 0; i < 81 && i < op_log.size(); i++)
      check($sformatf("arb_op%0d", i), op_log[i], (i % 9) != 8);
    check("arb_no_write_lost", wcount - wc0, acc);
    wait_drain(1000);

    // Backpressure: only RD_CREDITS reads until the consumer resumes
    for (int i = 0; i < 16; i++) exp_q.push_back({i == 15, exp_word(wbank_m, i)});
    rdo_ready = 1'b0;
    rc0 = rcount;
    pulse_sync(16);
    repeat (20) tick();
    check("bp_stall_reads", rcount - rc0, 4);
    check("bp_rdo_valid", rdo_valid, 1);
    check("bp_busy", busy, 1);
    rdo_ready = 1'b1;
    wait_drain(300);
    check("bp_total_reads", rcount - rc0, 16);
    for (int i = 0; i < 16; i++) do_write(i, 16'h3000 + 16'(i));

    // Overrun: restart on the other bank; in-flight words still delivered
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, exp_word(wbank_m, i)});
    for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, exp_word(~wbank_m, i)});
    rdo_ready = 1'b0;
    rc0 = rcount;
    pulse_sync(100);
    repeat (10) tick();
    check("ovr_pre_flag", rd_overrun, 0);
    check("ovr_pre_reads", rcount - rc0, 4);
    pulse_sync(8);
    check("ovr_flag", rd_overrun, 1);
    check("ovr_busy", busy, 1);
    rdo_ready = 1'b1;
    wait_drain(300);
    check("ovr_total_reads", rcount - rc0, 12);
    check("ovr_sticky", rd_overrun, 1);

    // Write coincident with frame_sync uses the old bank; frame_words=0 starts nothing
    rc0 = rcount;
    frame_sync = 1'b1; frame_words = '0;
    wr_valid = 1'b1; wr_addr = 22'd5; wr_data = 16'h4005;
    @(negedge clk);
    check("sync_wr_ready", wr_ready, 1);
    @(posedge clk); #1;
    frame_sync = 1'b0; wr_valid = 1'b0;
    check("sync_wr_bank", sram_addr, {wbank_m, 22'd5});
    ref_mem[(int'(wbank_m) << 22) | 5] = 16'h4005;
    wbank_m = ~wbank_m;
    do_write(6, 16'h4006);
    repeat (4) tick();
    check("zero_len_busy", busy, 0);
    check("zero_len_reads", rcount - rc0, 0);

    // Disabled scheduler accepts nothing
    enable = 1'b0; wr_valid = 1'b1;
    @(negedge clk);
    check("dis_wr_ready", wr_ready, 0);
    tick();
    check("dis_sram_en", sram_en, 0);
    wr_valid = 1'b0; enable = 1'b1;
    tick();

    // Reset in the middle of a read with data in flight
    rdo_ready = 1'b0;
    pulse_sync(20);
    repeat (3) tick();
    check("mid_busy", busy, 1);
    wr_valid = 1'b1;
    resetb = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) tick();
    wr_valid = 1'b0;
    resetb = 1'b1;
    wbank_m = 1'b0;
    rdo_ready = 1'b1;
    repeat (6) tick();
    check("post_reset_rdo", rdo_valid, 0);
    rc0 = rcount;
    pulse_sync(4);
    repeat (6) tick();
    check("post_reset_busy", busy, 0);
    check("post_reset_reads", rcount - rc0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
